// File: rtl/serial_rx.sv
// Purpose: asynchronous start/data/stop serial receiver; deserialises rxd into a parallel word, LSB first.
// Latency: ok/fr_err appear one clock after the mid-stop-bit sample (3 clocks of sync/edge delay before START).
// Backpressure: none; ok/fr_err/par_err are one-cycle strobes that the consumer must take when they fire.
// Optional build macro PARITY_CHECK_EN adds an even-parity bit (state PAR) and the par_err strobe.
module serial_rx #(
  parameter int F_CLK = 50000000,
  parameter int BAUD  = 115200,
  parameter int N_BIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rxd,
  output logic [N_BIT-1:0] dat,
  output logic             ok,
  output logic             fr_err,
  output logic             busy
`ifdef PARITY_CHECK_EN
  ,
  output logic             par_err
`endif
);

  // Clocks per bit, truncated; must be at least 4 so the half-bit count is non-trivial.
  localparam int DIV = F_CLK / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int IW  = (N_BIT > 1) ? $clog2(N_BIT) : 1;

  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);
  localparam logic [IW-1:0] LAST_IX = IW'(N_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    idx;
  logic [N_BIT-1:0] sh;
  logic             rx_m;
  logic             rx_s;
  logic             rx_d;
  logic             fall;
`ifdef PARITY_CHECK_EN
  logic             par_bit;
`endif

  // Two-flop synchroniser plus one edge-detect flop; all preset high so reset release never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rxd;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  // A frame may only begin on a 1 -> 0 transition of the synchronised line, so a stuck-low line cannot retrigger.
  assign fall = rx_d & ~rx_s;

  // Frame state machine; all outputs are registered here, strobes default low every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      sh     <= '0;
      dat    <= '0;
      ok     <= 1'b0;
      fr_err <= 1'b0;
      busy   <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_bit <= 1'b0;
      par_err <= 1'b0;
`endif
    end else begin
      ok     <= 1'b0;
      fr_err <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          cnt <= '0;
          if (fall) begin
            state <= START;
            busy  <= 1'b1;
          end
        end

        // Wait half a bit, then confirm the line is still low; a high sample means the edge was a glitch.
        START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            idx <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // From here on every sample lands mid-bit, one full bit period after the previous one.
        DATA: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            sh  <= {rx_s, sh[N_BIT-1:1]};
            idx <= idx + 1'b1;
            if (idx == LAST_IX) begin
`ifdef PARITY_CHECK_EN
              state <= PAR;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

`ifdef PARITY_CHECK_EN
        PAR: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            par_bit <= rx_s;
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif

        // Leaving at mid-stop-bit gives half a bit of slack to catch an immediately following start edge.
        STOP: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
            if (rx_s) begin
`ifdef PARITY_CHECK_EN
              if ((^sh) ^ par_bit) begin
                par_err <= 1'b1;
              end else begin
                dat <= sh;
                ok  <= 1'b1;
              end
`else
              dat <= sh;
              ok  <= 1'b1;
`endif
            end else begin
              fr_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_rx.sv
// Purpose: randomized and directed frames against a frame-level model of serial_rx.
// Latency: strobes are predicted from the frame start time with bit-period arithmetic.
// Backpressure: none; every strobe is recorded by a monitor and compared to an expected event list.
module tb_serial_rx;

  localparam int F_CLK = 50000000;
  localparam int BAUD  = 5000000;
  localparam int N_BIT = 8;
  localparam int DIV   = F_CLK / BAUD;
`ifdef PARITY_CHECK_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  // Edge reaches START after 2 sync edges, half a bit to the start sample, then one bit per
  // remaining bit up to the stop sample; the strobe is visible just after that sample edge.
  localparam int LAT = 2 + DIV / 2 + (N_BIT + 1 + PB) * DIV;

  typedef struct {
    int         kind;   // 1 ok, 2 fr_err, 3 par_err
    int         cyc;
    logic [7:0] d;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic [7:0] dat;
  logic       ok;
  logic       fr_err;
  logic       busy;
`ifdef PARITY_CHECK_EN
  logic       par_err;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   both   = 0;
  ev_t  exp_q[$];
  ev_t  obs_q[$];
  logic [7:0] exp_dat;

  serial_rx #(.F_CLK(F_CLK), .BAUD(BAUD), .N_BIT(N_BIT)) dut (
    .clk    (clk),
    .rst    (rst),
    .rxd    (rxd),
    .dat    (dat),
    .ok     (ok),
    .fr_err (fr_err),
    .busy   (busy)
`ifdef PARITY_CHECK_EN
    ,
    .par_err(par_err)
`endif
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log every strobe cycle with its cycle stamp.
  always begin
    @(posedge clk);
    #1;
    if (ok) obs_q.push_back('{1, cyc, dat});
    if (fr_err) obs_q.push_back('{2, cyc, 8'h00});
`ifdef PARITY_CHECK_EN
    if (par_err) obs_q.push_back('{3, cyc, 8'h00});
    if (ok && par_err) both++;
`endif
    if (ok && fr_err) both++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, want);
    end
  endtask

  // Called right after a negedge; leaves at a negedge. Drives one whole frame then an idle gap.
  task automatic send_frame(input logic [7:0] d, input logic stopb, input logic parbad, input int gap);
    logic bq[$];
    int   sc;
    bq.push_back(1'b0);
    for (int i = 0; i < N_BIT; i++) bq.push_back(d[i]);
    if (PB == 1) bq.push_back((^d) ^ parbad);
    bq.push_back(stopb);
    sc = cyc + 1;
    foreach (bq[i]) begin
      rxd = bq[i];
      repeat (DIV) @(negedge clk);
      if (i == 0) chk("busy_mid", 32'(busy), 32'd1);
    end
    if (!stopb) begin
      exp_q.push_back('{2, sc + LAT, 8'h00});
    end else if (PB == 1 && parbad) begin
      exp_q.push_back('{3, sc + LAT, 8'h00});
    end else begin
      exp_q.push_back('{1, sc + LAT, d});
      exp_dat = d;
    end
    rxd = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic flush(input string tag);
    int n;
    repeat (30) @(negedge clk);
    chk({tag, "_nev"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_kind%0d", tag, i), 32'(obs_q[i].kind), 32'(exp_q[i].kind));
      chk($sformatf("%s_cyc%0d", tag, i), 32'(obs_q[i].cyc), 32'(exp_q[i].cyc));
      chk($sformatf("%s_d%0d", tag, i), 32'(obs_q[i].d), 32'(exp_q[i].d));
    end
    chk({tag, "_dat"}, 32'(dat), 32'(exp_dat));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] d;
    logic       stopb;
    logic       parbad;
    int         gap;
    logic [7:0] v55;
    rst     = 1'b1;
    rxd     = 1'b1;
    exp_dat = 8'h00;
    repeat (5) @(negedge clk);
    chk("rst_dat", 32'(dat), 32'd0);
    chk("rst_ok", 32'(ok), 32'd0);
    chk("rst_fr", 32'(fr_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
`ifdef PARITY_CHECK_EN
    chk("rst_par", 32'(par_err), 32'd0);
`endif
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Good frame.
    send_frame(8'hA5, 1'b1, 1'b0, 5);
    flush("a5");

    // Short low glitch: START entered, rejected at the half-bit sample.
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    @(negedge clk);
    chk("glitch_busy", 32'(busy), 32'd1);
    flush("glitch");

    // Bad stop bit keeps the old word.
    send_frame(8'h3C, 1'b0, 1'b0, 5);
    flush("frerr");

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b1, 1'b0, 0);
    send_frame(8'hFF, 1'b1, 1'b0, 5);
    flush("b2b");

    // Reset in the middle of bit 4 of 0x55 abandons it silently and clears dat.
    v55 = 8'h55;
    rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = v55[i];
      repeat (DIV) @(negedge clk);
    end
    rxd = v55[4];
    repeat (DIV / 2) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_dat", 32'(dat), 32'd0);
    exp_dat = 8'h00;
    @(negedge clk);
    rxd = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    flush("rst");
    send_frame(8'h81, 1'b1, 1'b0, 5);
    flush("x81");

    // Line held low (break): exactly one framing error, no restart until a new edge.
    begin
      int sc;
      sc = cyc + 1;
      rxd = 1'b0;
      repeat (15 * DIV) @(negedge clk);
      exp_q.push_back('{2, sc + LAT, 8'h00});
      rxd = 1'b1;
      repeat (DIV) @(negedge clk);
    end
    flush("break");

`ifdef PARITY_CHECK_EN
    send_frame(8'h07, 1'b1, 1'b0, 5);
    send_frame(8'h07, 1'b1, 1'b1, 5);
    flush("par");
`endif

    // Random frames, with random gaps (a bad stop needs at least one high cycle to make a new edge).
    for (int n = 0; n < 30; n++) begin
      d      = 8'($urandom);
      stopb  = ($urandom_range(0, 4) != 0);
      parbad = (PB == 1) ? ($urandom_range(0, 2) == 0) : 1'b0;
      gap    = stopb ? $urandom_range(0, 12) : $urandom_range(1, 12);
      send_frame(d, stopb, parbad, gap);
    end
    flush("rand");

    chk("exclusive", 32'(both), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_rx.md
Name: serial_rx

Overview:
- Receive end of the lab serial link.
- Deserialises an asynchronous start/data/stop frame on a single line `rxd` into a parallel byte and emits a one-cycle `ok` strobe per good frame.
- Sits opposite the start-strobe/serial generator side: transmitter frames go in, parallel words and error flags come out to the consuming logic.

Parameters:
- F_CLK, 50000000: system clock frequency in Hz.
- BAUD, 115200: line bit rate in bit/s.
- N_BIT, 8: data bits per frame, sent LSB first.
- DIV, F_CLK/BAUD (derived localparam, integer, truncated): clocks per bit. Must be >= 4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rxd  in  1  serial line; idle high; asynchronous to clk.
- dat  out  N_BIT  last correctly received word.
- ok  out  1  one-cycle strobe: `dat` updated with a good frame.
- fr_err  out  1  one-cycle strobe: stop bit sampled low.
- busy  out  1  high while a frame is being received (state != IDLE).

Behaviour:
- Reset: asynchronous, active-high, single clock clk. On assertion:
  - state = IDLE, dat = 0, ok = 0, fr_err = 0, busy = 0.
  - Both synchroniser flops are set to 1, so no false start is seen on release.
  - Reset mid-frame abandons the frame; no strobe is issued.
- Input path: `rxd` passes through a 2-flop synchroniser (`rx_s`). A start edge is `rx_s` going 1 -> 0, detected with one more flop.
- Bit counter `cnt` is $clog2(DIV) bits wide. Bit index `idx` runs 0..N_BIT-1. Shift register `sh` is N_BIT wide, filled LSB first (shift right, new bit into MSB).
- State machine:
  - IDLE: on detected falling edge -> START, cnt = 0.
  - START: count to cnt == DIV/2-1, then sample `rx_s`.
    - 0: valid start -> DATA, cnt = 0, idx = 0.
    - 1: glitch -> IDLE, no strobe.
  - DATA: sample at cnt == DIV-1, then cnt = 0.
    - Shift the sample into `sh`, idx++.
    - After sample N_BIT-1 -> STOP (or PAR when PARITY_CHECK_EN is defined).
  - STOP: sample at cnt == DIV-1.
    - 1: dat <= sh, ok = 1 for the next cycle only.
    - 0: fr_err = 1 for the next cycle only; dat unchanged.
    - Both cases -> IDLE.
- Sample timing: with the edge detected on cycle t, bit k (start = 0) is sampled at cycle t + DIV/2 + k*DIV, i.e. mid-bit.
- Latency: `ok` goes high 1 cycle after the stop-bit sample cycle.
- Back-to-back frames:
  - IDLE is re-entered half a bit before the end of the stop bit, so a start edge immediately following the stop bit is caught.
  - No dead time is required by the transmitter.
- Line stuck low (break):
  - Produces fr_err once.
  - No further frames until `rx_s` returns high and falls again; only an edge starts a frame.
- `ok` and `fr_err` are never high in the same cycle.
- `busy` is registered with the state: high from START through the stop-sample cycle.

Optional Feature:
- Macro: PARITY_CHECK_EN.
- Defined:
  - Frame carries one even-parity bit after the data bits, in extra state PAR, sampled at cnt == DIV-1.
  - Extra port `par_err` (out, 1): one-cycle strobe.
  - If XOR(sh, parity bit) != 0 and stop = 1: par_err pulses in the same cycle that ok would have; ok is suppressed and dat is unchanged.
  - Stop = 0 reports fr_err only.
  - Reset value of par_err = 0.
- Undefined: no PAR state, no `par_err` port; frame = start + N_BIT + stop.

Test Plan:
- All benches: Tclk = 20 ns, F_CLK = 50000000, BAUD = 5000000 (DIV = 10), rst held 100 ns.
1. Frame 0xA5 (LSB first, one stop bit) -> dat = 8'hA5, ok high exactly 1 cycle, 1 cycle after the stop sample; fr_err = 0; busy falls back to 0.
2. rxd low for 3 clocks, then high -> no ok, no fr_err; busy high ~5 cycles, then 0; dat keeps its prior value.
3. Frame 0x3C followed by stop bit = 0 -> fr_err 1-cycle pulse; ok = 0; dat still 8'hA5 from scenario 1.
4. Back-to-back frames 0x00 then 0xFF with no idle gap -> two ok pulses 100 cycles apart; dat = 8'h00, then 8'hFF.
5. Assert rst during bit 4 of frame 0x55, release, send 0x81 -> no strobe for 0x55; after reset dat = 0; then dat = 8'h81 with ok.
6. With PARITY_CHECK_EN: 0x07 with parity 1 -> ok, dat = 8'h07; 0x07 with parity 0 -> par_err pulse, no ok, dat unchanged.
